// File: rtl/tank_drive_pwm.sv
// Dual-track PWM motor driver: filters a packed signed speed command, slew-limits
// each track's magnitude and forces reversals through zero with a dead-time.

module track_channel #(
  parameter int DEAD_PERIODS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       boundary,
  input  logic [2:0] slot,
  input  logic [3:0] target,
  output logic       pwm,
  output logic       dir,
  output logic [2:0] mag
);

  typedef enum logic {RUN, DEAD} state_t;

  state_t     state;
  logic [3:0] deadcnt;
  logic [3:0] abs_val;
  logic [2:0] tgt_mag;
  logic       tgt_dir;

  // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
  always_comb begin
    abs_val = target;
    if (target[3]) abs_val = ~target + 4'd1;
    // -8 has no positive 4-bit counterpart; it saturates to full speed.
    tgt_mag = abs_val[3] ? 3'd7 : abs_val[2:0];
    tgt_dir = (tgt_mag == 3'd0) ? dir : target[3];
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= RUN;
      mag     <= 3'd0;
      dir     <= 1'b0;
      deadcnt <= 4'd0;
      pwm     <= 1'b0;
    end else begin
      pwm <= enable && (slot < mag);
      if (!enable) begin
        state   <= RUN;
        mag     <= 3'd0;
        deadcnt <= 4'd0;
      end else if (boundary) begin
        case (state)
          RUN: begin
            if (tgt_dir == dir) begin
              if (mag < tgt_mag)      mag <= mag + 3'd1;
              else if (mag > tgt_mag) mag <= mag - 3'd1;
            end else if (mag != 3'd0) begin
              mag <= mag - 3'd1;
            end else begin
              state   <= DEAD;
              deadcnt <= 4'(DEAD_PERIODS);
            end
          end
          DEAD: begin
            // Direction is taken from whatever the target is when the dead-time expires.
            if (deadcnt == 4'd1) begin
              dir     <= tgt_dir;
              state   <= RUN;
              deadcnt <= 4'd0;
            end else begin
              deadcnt <= deadcnt - 4'd1;
            end
          end
          default: state <= RUN;
        endcase
      end
    end
  end

endmodule

module tank_drive_pwm #(
  parameter int PRESCALE     = 7143,
  parameter int DEAD_PERIODS = 4
) (
  input  logic       clk_clk,
  input  logic       reset_reset,
  input  logic [7:0] cmd_export,
  input  logic       enable,
  output logic       left_pwm,
  output logic       left_dir,
  output logic       right_pwm,
  output logic       right_dir,
  output logic       moving
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0] presc;
  logic [2:0]    slot;
  logic          presc_wrap;
  logic          boundary;
  logic [7:0]    q1, q2, target;
  logic [2:0]    left_mag, right_mag;

  assign presc_wrap = (presc == PW'(PRESCALE - 1));
  assign boundary   = presc_wrap && (slot == 3'd6);

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      presc <= '0;
      slot  <= 3'd0;
    end else if (presc_wrap) begin
      presc <= '0;
      slot  <= (slot == 3'd6) ? 3'd0 : slot + 3'd1;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  // A command is accepted only after two identical consecutive samples.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      q1     <= 8'h00;
      q2     <= 8'h00;
      target <= 8'h00;
    end else begin
      q1 <= cmd_export;
      q2 <= q1;
      if (q1 == q2) target <= q2;
    end
  end

  track_channel #(.DEAD_PERIODS(DEAD_PERIODS)) u_left (
    .clk      (clk_clk),
    .rst      (reset_reset),
    .enable   (enable),
    .boundary (boundary),
    .slot     (slot),
    .target   (target[7:4]),
    .pwm      (left_pwm),
    .dir      (left_dir),
    .mag      (left_mag)
  );

  track_channel #(.DEAD_PERIODS(DEAD_PERIODS)) u_right (
    .clk      (clk_clk),
    .rst      (reset_reset),
    .enable   (enable),
    .boundary (boundary),
    .slot     (slot),
    .target   (target[3:0]),
    .pwm      (right_pwm),
    .dir      (right_dir),
    .mag      (right_mag)
  );

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) moving <= 1'b0;
    else             moving <= (left_mag != 3'd0) || (right_mag != 3'd0);
  end

endmodule

// File: tb/tb_tank_drive_pwm.sv
// Directed bench for tank_drive_pwm: per-period PWM patterns, dirs and moving
// against hand-derived magnitude sequences (PRESCALE=3, DEAD_PERIODS=2).

module tb_tank_drive_pwm;

  localparam int P  = 3;
  localparam int DP = 2;
  localparam int PERIOD_CLKS = 7 * P;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] cmd = 8'h00;
  logic       en  = 1'b1;
  logic       left_pwm, left_dir, right_pwm, right_dir, moving;

  int n_checks = 0;
  int n_errors = 0;
  int pnum     = 0;

  tank_drive_pwm #(.PRESCALE(P), .DEAD_PERIODS(DP)) dut (
    .clk_clk     (clk),
    .reset_reset (rst),
    .cmd_export  (cmd),
    .enable      (en),
    .left_pwm    (left_pwm),
    .left_dir    (left_dir),
    .right_pwm   (right_pwm),
    .right_dir   (right_dir),
    .moving      (moving)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Sample i of a period reflects slot i/P, so magnitude m is high for the first P*m samples.
  function automatic logic [31:0] exp_pat(input int m);
    return (32'd1 << (P * m)) - 32'd1;
  endfunction

  // Runs one full PWM period starting just before its first clock edge.
  task automatic period(input logic [7:0] c, input int lm, input int rm,
                        input logic ld, input logic rd);
    logic [31:0] lp, rp;
    logic mv, ldr, rdr;
    cmd = c;
    lp = '0; rp = '0; mv = 1'b0; ldr = 1'b0; rdr = 1'b0;
    for (int i = 0; i < PERIOD_CLKS; i++) begin
      @(negedge clk);
      lp[i] = left_pwm;
      rp[i] = right_pwm;
      if (i == 0) begin
        mv  = moving;
        ldr = left_dir;
        rdr = right_dir;
      end
    end
    check($sformatf("p%0d_left_pwm", pnum), lp, exp_pat(lm));
    check($sformatf("p%0d_right_pwm", pnum), rp, exp_pat(rm));
    check($sformatf("p%0d_left_dir", pnum), 32'(ldr), 32'(ld));
    check($sformatf("p%0d_right_dir", pnum), 32'(rdr), 32'(rd));
    check($sformatf("p%0d_moving", pnum), 32'(mv), 32'((lm != 0) || (rm != 0)));
    pnum++;
  endtask

  initial begin
    logic seen;

    // Reset state and glitch rejection.
    repeat (3) @(negedge clk);
    check("reset_outputs", {left_pwm, left_dir, right_pwm, right_dir, moving}, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    cmd = 8'h30;
    @(negedge clk);
    cmd = 8'h00;
    seen = 1'b0;
    for (int i = 0; i < 3 * PERIOD_CLKS; i++) begin
      @(negedge clk);
      seen = seen | left_pwm | right_pwm | moving;
    end
    check("glitch_rejected", 32'(seen), 0);

    // Reset held with 0x77, then ramp 0..7 and a full left reversal.
    cmd = 8'h77;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_with_cmd", {left_pwm, left_dir, right_pwm, right_dir, moving}, 0);
    rst = 1'b0;
    pnum = 0;
    for (int k = 0; k <= 7; k++) period(8'h77, k, k, 1'b0, 1'b0);
    period(8'h90, 7, 7, 1'b0, 1'b0);
    for (int k = 6; k >= 0; k--) period(8'h90, k, k, 1'b0, 1'b0);
    repeat (DP) period(8'h90, 0, 0, 1'b0, 1'b0);
    for (int k = 0; k <= 7; k++) period(8'h90, k, 0, 1'b1, 1'b0);

    // Asynchronous reset while the left track is at full reverse.
    repeat (2) @(negedge clk);
    check("pre_reset_left_pwm", 32'(left_pwm), 1);
    #1;
    rst = 1'b1;
    cmd = 8'h08;
    #1;
    check("async_reset_outputs", {left_pwm, left_dir, right_pwm, right_dir, moving}, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Right -8 clamps to 7 after the dead-time from the reset state.
    pnum = 100;
    repeat (DP + 1) period(8'h08, 0, 0, 1'b0, 1'b0);
    for (int k = 0; k <= 7; k++) period(8'h08, 0, k, 1'b0, 1'b1);

    // Left +3, then -3, then +3 restored during the dead-time.
    period(8'h30, 0, 7, 1'b0, 1'b1);
    period(8'h30, 1, 6, 1'b0, 1'b1);
    period(8'h30, 2, 5, 1'b0, 1'b1);
    period(8'h30, 3, 4, 1'b0, 1'b1);
    period(8'hD0, 3, 3, 1'b0, 1'b1);
    period(8'hD0, 2, 2, 1'b0, 1'b1);
    period(8'hD0, 1, 1, 1'b0, 1'b1);
    period(8'hD0, 0, 0, 1'b0, 1'b1);
    repeat (DP + 1) period(8'h30, 0, 0, 1'b0, 1'b1);
    for (int k = 1; k <= 3; k++) period(8'h30, k, 0, 1'b0, 1'b1);
    period(8'h50, 3, 0, 1'b0, 1'b1);
    period(8'h50, 4, 0, 1'b0, 1'b1);
    period(8'h50, 5, 0, 1'b0, 1'b1);

    // Enable drop mid-slot at magnitude 5.
    repeat (4) @(negedge clk);
    check("en_pre_left_pwm", 32'(left_pwm), 1);
    en = 1'b0;
    @(negedge clk);
    check("en_drop_left_pwm", 32'(left_pwm), 0);
    check("en_drop_moving_lag", 32'(moving), 1);
    @(negedge clk);
    check("en_drop_moving", 32'(moving), 0);
    check("en_drop_dirs_held", {left_dir, right_dir}, 2'b01);
    seen = 1'b0;
    for (int i = 6; i < PERIOD_CLKS; i++) begin
      @(negedge clk);
      seen = seen | left_pwm | right_pwm | moving;
    end
    check("en_low_quiet", 32'(seen), 0);
    en = 1'b1;
    pnum = 200;
    for (int k = 0; k <= 2; k++) period(8'h50, k, 0, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
